// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, datapath select codes, FSM states.
package rv_ctrl_pkg;

   localparam int unsigned OPC_W = 7;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_JALR  = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_PC   = 2'd1,
      A_ZERO = 2'd2
   } alu_a_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_e;

   // funct7_5 selects SUB only for register-register ops; it always selects SRA for shifts.
   function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic f7_5,
                                              input logic is_r);
      alu_op_e op;
      case (f3)
         3'b000:  op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Opcode/funct decode into ALU operation, immediate format and a legal-opcode flag.
module mc_alu_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output alu_op_e    alu_ctrl,
   output imm_sel_e   imm_sel,
   output logic       legal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      imm_sel  = IMM_I;
      legal    = 1'b1;
      case (opcode)
         OP_R:      alu_ctrl = alu_from_funct(funct3, funct7_5, 1'b1);
         OP_IMM:    alu_ctrl = alu_from_funct(funct3, funct7_5, 1'b0);
         OP_LOAD:   imm_sel  = IMM_I;
         OP_STORE:  imm_sel  = IMM_S;
         OP_BRANCH: begin
            alu_ctrl = ALU_SUB;
            imm_sel  = IMM_B;
         end
         OP_JAL:    imm_sel  = IMM_J;
         OP_JALR:   imm_sel  = IMM_I;
         OP_LUI,
         OP_AUIPC:  imm_sel  = IMM_U;
         default:   legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer sharing one ALU and one memory port.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic        br_cond,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic [1:0]  alu_src_a,
   output logic        alu_src_b,
   output logic [3:0]  alu_ctrl,
   output logic [2:0]  imm_sel,
   output logic        instr_retired,
   output logic        trap,
   output logic        trap_cause,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q;
   logic               cause_q, cause_d;
   logic               wait_hit;
   logic               mem_wait;
   alu_op_e            dec_alu;
   imm_sel_e           dec_imm;
   logic               dec_legal;

   mc_alu_decode u_dec (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_ctrl (dec_alu),
      .imm_sel  (dec_imm),
      .legal    (dec_legal)
   );

   assign mem_wait = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
   assign wait_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == CNT_W'(WAIT_LIMIT));

   // State, wait counter and latched trap cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         cause_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mem_wait && (state_d == state_q)) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
         else                                  wait_cnt_q <= '0;
         if ((state_d == TRAP) && (state_q != TRAP)) cause_q <= cause_d;
      end
   end

   // Next state and all datapath controls.
   always_comb begin
      state_d       = state_q;
      cause_d       = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = PC_PLUS4;
      reg_we        = 1'b0;
      wb_sel        = WB_ALU;
      alu_src_a     = A_RS1;
      alu_src_b     = 1'b0;
      alu_ctrl      = ALU_ADD;
      imm_sel       = IMM_I;
      instr_retired = 1'b0;
      trap          = 1'b0;
      trap_cause    = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end else if (wait_hit) begin
               cause_d = 1'b1;
               state_d = TRAP;
            end
         end
         DECODE: state_d = dec_legal ? EXEC : TRAP;
         EXEC: begin
            alu_ctrl = dec_alu;
            imm_sel  = dec_imm;
            case (opcode)
               OP_R: state_d = WB;
               OP_IMM: begin
                  alu_src_b = 1'b1;
                  state_d   = WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 1'b1;
                  state_d   = MEM;
               end
               OP_BRANCH: begin
                  pc_we         = 1'b1;
                  pc_src        = br_cond ? PC_IMM : PC_PLUS4;
                  instr_retired = 1'b1;
                  state_d       = FETCH;
               end
               OP_JAL, OP_JALR: begin
                  reg_we        = 1'b1;
                  wb_sel        = WB_PC4;
                  pc_we         = 1'b1;
                  pc_src        = (opcode == OP_JAL) ? PC_IMM : PC_JALR;
                  instr_retired = 1'b1;
                  state_d       = FETCH;
               end
               OP_LUI, OP_AUIPC: begin
                  alu_src_a = (opcode == OP_LUI) ? A_ZERO : A_PC;
                  alu_src_b = 1'b1;
                  state_d   = WB;
               end
               default: state_d = TRAP;
            endcase
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  pc_we         = 1'b1;
                  instr_retired = 1'b1;
                  state_d       = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (wait_hit) begin
               cause_d = 1'b1;
               state_d = TRAP;
            end
         end
         WB: begin
            reg_we        = 1'b1;
            wb_sel        = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = FETCH;
         end
         TRAP: begin
            trap       = 1'b1;
            trap_cause = cause_q;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_q, instret_q;

   // Counters run in every active state and hold while trapped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if ((state_q != IDLE) && (state_q != TRAP)) cycle_q <= cycle_q + 32'd1;
         if (instr_retired) instret_q <= instret_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; each cycle compares the full control word.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        br_cond;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_src_b;
   logic        instr_retired, trap, trap_cause;
   logic [1:0]  pc_src, wb_sel, alu_src_a;
   logic [3:0]  alu_ctrl;
   logic [2:0]  imm_sel;
   logic [31:0] cycle_cnt, instret_cnt;
   logic [22:0] obs;

   int n_vec = 0;
   int n_err = 0;
   int n_ret = 0;

   multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .br_cond       (br_cond),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr_sel  (mem_addr_sel),
      .ir_we         (ir_we),
      .pc_we         (pc_we),
      .pc_src        (pc_src),
      .reg_we        (reg_we),
      .wb_sel        (wb_sel),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctrl      (alu_ctrl),
      .imm_sel       (imm_sel),
      .instr_retired (instr_retired),
      .trap          (trap),
      .trap_cause    (trap_cause),
      .cycle_cnt     (cycle_cnt),
      .instret_cnt   (instret_cnt)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
                 alu_src_a, alu_src_b, alu_ctrl, imm_sel, instr_retired, trap, trap_cause};

   // Control word: req we asel ir_we pc_we pc_src reg_we wb_sel src_a src_b alu imm ret trap cause
   function automatic logic [22:0] cw(int req, int we, int as, int ir, int pw, int ps, int rw,
                                      int ws, int a, int b, int alu, int imm, int ret, int tr,
                                      int tc);
      return {1'(req), 1'(we), 1'(as), 1'(ir), 1'(pw), 2'(ps), 1'(rw), 2'(ws), 2'(a), 1'(b),
              4'(alu), 3'(imm), 1'(ret), 1'(tr), 1'(tc)};
   endfunction

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f7;
   endtask

   // Entered just after a rising edge: drive, sample, advance one cycle.
   task automatic step(input string tag, input logic rdy, input logic bc,
                       input logic [22:0] exp);
      mem_ready = rdy;
      br_cond   = bc;
      #1;
      check_vec(tag, 32'(obs), 32'(exp));
      if (exp[2]) n_ret++;
      @(posedge clk);
      #1;
   endtask

   logic [22:0] f_rdy, f_wait, wb_alu;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      f_rdy  = cw(1,0,0,1, 0,0,0,0, 0,0,0,0, 0,0,0);
      f_wait = cw(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0);
      wb_alu = cw(0,0,0,0, 1,0,1,0, 0,0,0,0, 1,0,0);
      rst_n = 1'b0;
      set_ir(7'd0, 3'd0, 1'b0);
      br_cond   = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_vec("rst_outs", 32'(obs), 32'd0);
      check_vec("rst_cyc", cycle_cnt, 32'd0);
      check_vec("rst_ret", instret_cnt, 32'd0);
      rst_n = 1'b1;
      step("idle", 0, 0, 23'd0);

      set_ir(7'b0110011, 3'b000, 1'b0);
      step("add_f",  1, 0, f_rdy);
      step("add_d",  1, 0, 23'd0);
      step("add_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
      step("add_wb", 1, 0, wb_alu);

      set_ir(7'b0110011, 3'b000, 1'b1);
      step("sub_f",  1, 0, f_rdy);
      step("sub_d",  1, 0, 23'd0);
      step("sub_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 0,0,1,0, 0,0,0));
      step("sub_wb", 1, 0, wb_alu);

      set_ir(7'b0010011, 3'b101, 1'b1);
      step("srai_f",  1, 0, f_rdy);
      step("srai_d",  1, 0, 23'd0);
      step("srai_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 0,1,7,0, 0,0,0));
      step("srai_wb", 1, 0, wb_alu);

      set_ir(7'b0000011, 3'b010, 1'b0);
      step("lw_f",  1, 0, f_rdy);
      step("lw_d",  1, 0, 23'd0);
      step("lw_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0));
      for (int i = 0; i < 3; i++) step("lw_mwait", 0, 0, cw(1,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0));
      step("lw_m",  1, 0, cw(1,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0));
      step("lw_wb", 1, 0, cw(0,0,0,0, 1,0,1,1, 0,0,0,0, 1,0,0));

      set_ir(7'b0100011, 3'b010, 1'b0);
      step("sw_f", 1, 0, f_rdy);
      step("sw_d", 1, 0, 23'd0);
      step("sw_e", 1, 0, cw(0,0,0,0, 0,0,0,0, 0,1,0,1, 0,0,0));
      step("sw_m", 1, 0, cw(1,1,1,0, 1,0,0,0, 0,0,0,0, 1,0,0));

      set_ir(7'b1100011, 3'b000, 1'b0);
      step("beqt_f", 1, 1, f_rdy);
      step("beqt_d", 1, 1, 23'd0);
      step("beqt_e", 1, 1, cw(0,0,0,0, 1,1,0,0, 0,0,1,2, 1,0,0));
      step("beqn_f", 1, 0, f_rdy);
      step("beqn_d", 1, 0, 23'd0);
      step("beqn_e", 1, 0, cw(0,0,0,0, 1,0,0,0, 0,0,1,2, 1,0,0));

      set_ir(7'b1100111, 3'b000, 1'b0);
      step("jalr_f", 1, 0, f_rdy);
      step("jalr_d", 1, 0, 23'd0);
      step("jalr_e", 1, 0, cw(0,0,0,0, 1,2,1,2, 0,0,0,0, 1,0,0));

      set_ir(7'b1101111, 3'b000, 1'b0);
      step("jal_f", 1, 0, f_rdy);
      step("jal_d", 1, 0, 23'd0);
      step("jal_e", 1, 0, cw(0,0,0,0, 1,1,1,2, 0,0,0,4, 1,0,0));

      set_ir(7'b0110111, 3'b000, 1'b0);
      step("lui_f",  1, 0, f_rdy);
      step("lui_d",  1, 0, 23'd0);
      step("lui_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 2,1,0,3, 0,0,0));
      step("lui_wb", 1, 0, wb_alu);

      set_ir(7'b0010111, 3'b000, 1'b0);
      step("auipc_f",  1, 0, f_rdy);
      step("auipc_d",  1, 0, 23'd0);
      step("auipc_e",  1, 0, cw(0,0,0,0, 0,0,0,0, 1,1,0,3, 0,0,0));
      step("auipc_wb", 1, 0, wb_alu);

      // Ready on the limit cycle beats the timeout.
      set_ir(7'b0110011, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) step("lim_fwait", 0, 0, f_wait);
      step("lim_f",  1, 0, f_rdy);
      step("lim_d",  1, 0, 23'd0);
      step("lim_e",  1, 0, 23'd0);
      step("lim_wb", 1, 0, wb_alu);

      for (int i = 0; i < 5; i++) step("to_fwait", 0, 0, f_wait);
      step("to_trap",  0, 0, cw(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,1));
      step("to_hold",  1, 0, cw(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,1));
`ifdef MULTICYCLE_PERF_EN
      check_vec("instret", instret_cnt, 32'(n_ret));
`else
      check_vec("cyc_off", cycle_cnt, 32'd0);
      check_vec("ret_off", instret_cnt, 32'd0);
`endif

      rst_n = 1'b0;
      #1;
      check_vec("rst_trap", 32'(obs), 32'd0);
      check_vec("rst_ret2", instret_cnt, 32'd0);
      rst_n = 1'b1;
      step("idle2",  0, 0, 23'd0);
      step("f_wait", 0, 0, f_wait);
      rst_n = 1'b0;
      #1;
      check_vec("rst_mid", 32'(obs), 32'd0);
      rst_n = 1'b1;
      step("idle3", 0, 0, 23'd0);

      set_ir(7'b1111111, 3'b000, 1'b0);
      step("ill_f",    1, 0, f_rdy);
      step("ill_d",    1, 0, 23'd0);
      step("ill_trap", 1, 0, cw(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0));
      step("ill_hold", 1, 0, cw(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer that reuses one ALU and one unified instruction/data memory port across several cycles per instruction, for RV32I base opcodes.
- Decodes the registered instruction fields (opcode, funct3, funct7_5) and steps the datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- Drives all datapath enables, mux selects and the memory request handshake.
- Sits between the instruction register and the shared ALU, register file and memory port.

Parameters:
- WAIT_LIMIT, 255: maximum consecutive memory-wait cycles before entering TRAP; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- br_cond  in  1  datapath comparator result for the current branch's funct3.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write request; valid only with mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- reg_we  out  1  register-file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_ctrl  out  4  ALU operation code.
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  high while in TRAP.
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout.
- cycle_cnt  out  32  cycle counter (see Optional Feature).
- instret_cnt  out  32  retired-instruction counter (see Optional Feature).

Behaviour:
- State register only; all outputs are combinational from state, opcode, funct3, funct7_5, br_cond and mem_ready.
- Reset:
  - rst_n low forces IDLE asynchronously. Mid-transaction, mem_req drops in the same cycle.
  - In IDLE every output is 0, including the counters.
- IDLE: next state FETCH unconditionally.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir_we=1, next DECODE.
  - mem_ready=0: hold FETCH.
- DECODE: one cycle, no strobes.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: next TRAP with trap_cause=0.
- EXEC: ALU operation per opcode.
  - R/I-type: alu_ctrl from funct3/funct7_5. I-type uses funct7_5 only for SRAI. Next WB.
  - Load/store: alu_ctrl=ADD, alu_src_b=1, imm_sel I or S. Next MEM.
  - Branch: alu_ctrl=SUB, imm_sel=B, pc_we=1, pc_src = br_cond ? 1 : 0, instr_retired=1. Next FETCH.
  - JAL: imm_sel=J, reg_we=1, wb_sel=2, pc_we=1, pc_src=1, retire. Next FETCH.
  - JALR: imm_sel=I, reg_we=1, wb_sel=2, pc_we=1, pc_src=2, retire. Next FETCH.
  - LUI: alu_src_a=2, alu_src_b=1, imm_sel=U, ADD. Next WB.
  - AUIPC: alu_src_a=1, alu_src_b=1, imm_sel=U, ADD. Next WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store. Held stable until mem_ready.
  - Load completes: next WB.
  - Store completes: pc_we=1, pc_src=0, retire; next FETCH.
- WB: reg_we=1 (wb_sel=1 for load, else 0), pc_we=1, pc_src=0, retire. Next FETCH.
- TRAP: all strobes 0, trap=1, trap_cause held. Exits only via reset.
- Latency with zero-wait memory (mem_ready high on the first request cycle):
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on state change.
  - When it equals WAIT_LIMIT (WAIT_LIMIT≠0) with mem_ready still 0: next TRAP, trap_cause=1.
  - mem_ready on the limit cycle wins over the timeout.
- Encodings:
  - ALU: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - Strobes not listed for a state are 0; selects not listed are 0.

Optional Feature:
- MULTICYCLE_PERF_EN defined:
  - cycle_cnt increments every cycle outside IDLE.
  - instret_cnt increments on instr_retired.
  - Both 32-bit, wrap at 2^32, clear on reset, freeze in TRAP.
- Undefined: both outputs tied to 0 and no counter flops are built.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants;
  - ALU, imm_sel, pc_src, wb_sel and alu_src_a codes;
  - the state enumeration (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP).
- One combinational sub-module, mc_alu_decode: opcode/funct3/funct7_5 -> alu_ctrl, imm_sel, legal flag.

Test Plan:
- ADD, zero-wait: opcode=0110011, funct3=000, funct7_5=0, mem_ready=1 -> states FETCH→DECODE→EXEC→WB. Single reg_we in WB with wb_sel=0, alu_ctrl=0000, instr_retired at cycle 4. Same sequence with funct7_5=1 -> alu_ctrl=0001.
- LW with 3 wait cycles: opcode=0000011, mem_ready low 3 cycles in MEM -> mem_req/mem_addr_sel=1/mem_we=0 stable for 4 cycles, then WB with reg_we=1, wb_sel=1. Retire at cycle 8.
- Branch: BEQ with br_cond=1 -> EXEC shows pc_we=1, pc_src=1, imm_sel=010. With br_cond=0 -> pc_src=0. Each retires in 3 cycles.
- JALR: opcode=1100111 -> EXEC drives reg_we=1, wb_sel=2, pc_src=2. Next state FETCH.
- Illegal opcode 1111111 -> TRAP after DECODE: trap=1, trap_cause=0, no further mem_req. rst_n pulse -> IDLE, all outputs 0, then FETCH.
- Timeout, WAIT_LIMIT=4: mem_ready held 0 in FETCH -> TRAP on the cycle after count reaches 4, trap_cause=1. Repeat with mem_ready=1 on the limit cycle -> DECODE, no trap.
